// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: reset sequencer that follows the power-on reset generator.
// It releases NUM_DOM reset domains one at a time in index order, with a
// programmable step delay between releases. Afterwards it serves per-domain
// soft-reset requests (a domain's reset also holds every higher-index
// domain) and full-chip restart requests. All outputs are registered.
module rst_seq_ctrl #(
   parameter int unsigned NUM_DOM = 4,
   parameter int unsigned DLY_W   = 8
) (
   input  logic               mclk,
   input  logic               reset,
   input  logic [DLY_W-1:0]   cfg_dly,
   input  logic               full_rst_req,
   input  logic [NUM_DOM-1:0] sw_rst_req,
   output logic [NUM_DOM-1:0] sw_rst_ack,
   output logic [NUM_DOM-1:0] dom_rst_n,
   output logic               seq_busy,
   output logic               seq_done
);

   localparam int unsigned IDX_W = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOM - 1);

   typedef enum logic {
      ST_HOLD,
      ST_DONE
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [DLY_W-1:0]   r_cnt;
   logic [DLY_W-1:0]   r_dly;
   logic [NUM_DOM-1:0] r_dom_rst_n;
   logic [NUM_DOM-1:0] r_ack;
   logic               r_busy;
   logic               r_done;

   logic [DLY_W-1:0]   w_eff;
   logic [DLY_W:0]     w_cnt_inc;
   logic               w_step_hit;
   logic               w_req_any;
   logic [IDX_W-1:0]   w_sel_idx;
   logic [NUM_DOM-1:0] w_keep;

   // Effective step delay: a programmed 0 behaves as 1 so the sequence never stalls
   always_comb begin
      w_eff      = (r_dly == '0) ? {{(DLY_W-1){1'b0}}, 1'b1} : r_dly;
      w_cnt_inc  = {1'b0, r_cnt} + {{DLY_W{1'b0}}, 1'b1};
      w_step_hit = (w_cnt_inc == {1'b0, w_eff});
   end

   // Pick the lowest-index pending soft request and the domains it leaves running
   always_comb begin
      w_req_any = 1'b0;
      w_sel_idx = '0;
      w_keep    = '0;
      for (int unsigned i = 0; i < NUM_DOM; i++) begin
         if (sw_rst_req[i] && !w_req_any) begin
            w_req_any = 1'b1;
            w_sel_idx = IDX_W'(i);
         end
      end
      for (int unsigned j = 0; j < NUM_DOM; j++) begin
         w_keep[j] = (IDX_W'(j) < w_sel_idx);
      end
   end

   // Sequencer FSM: reset/full restart, timed releases, soft-request acceptance
   always_ff @(posedge mclk) begin
      if (reset || full_rst_req) begin
         r_state     <= ST_HOLD;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_dly       <= cfg_dly;
         r_dom_rst_n <= '0;
         r_ack       <= '0;
         r_busy      <= 1'b1;
         r_done      <= 1'b0;
      end else begin
         r_ack <= '0;
         case (r_state)
            ST_HOLD: begin
               if (w_step_hit) begin
                  r_dom_rst_n[r_idx] <= 1'b1;
                  r_cnt              <= '0;
                  if (r_idx == LAST_IDX) begin
                     r_state <= ST_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else begin
                  r_cnt <= w_cnt_inc[DLY_W-1:0];
               end
            end
            ST_DONE: begin
               // Every domain is released here, so the post-accept vector is just w_keep
               if (w_req_any) begin
                  r_ack              <= '0;
                  r_ack[w_sel_idx]   <= 1'b1;
                  r_dom_rst_n        <= w_keep;
                  r_idx              <= w_sel_idx;
                  r_cnt              <= '0;
                  r_dly              <= cfg_dly;
                  r_busy             <= 1'b1;
                  r_done             <= 1'b0;
                  r_state            <= ST_HOLD;
               end
            end
            default: begin
               r_state <= ST_HOLD;
            end
         endcase
      end
   end

   assign sw_rst_ack = r_ack;
   assign dom_rst_n  = r_dom_rst_n;
   assign seq_busy   = r_busy;
   assign seq_done   = r_done;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: stimulus tasks push time-stamped
// expected output vectors into a scoreboard; a negedge monitor pops and
// compares them as the DUT reaches each edge.
module tb_rst_seq_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;

   logic          mclk;
   logic          reset;
   logic [DW-1:0] cfg_dly;
   logic          full_rst_req;
   logic [N-1:0]  sw_rst_req;
   logic [N-1:0]  sw_rst_ack;
   logic [N-1:0]  dom_rst_n;
   logic          seq_busy;
   logic          seq_done;

   rst_seq_ctrl #(
      .NUM_DOM (N),
      .DLY_W   (DW)
   ) u_dut (
      .mclk         (mclk),
      .reset        (reset),
      .cfg_dly      (cfg_dly),
      .full_rst_req (full_rst_req),
      .sw_rst_req   (sw_rst_req),
      .sw_rst_ack   (sw_rst_ack),
      .dom_rst_n    (dom_rst_n),
      .seq_busy     (seq_busy),
      .seq_done     (seq_done)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   int unsigned cyc = 0;
   always @(posedge mclk) cyc <= cyc + 1;

   typedef struct {
      int unsigned at;
      string       tag;
      logic [N-1:0] dom;
      logic [N-1:0] ack;
      logic        busy;
      logic        done;
   } exp_t;

   exp_t        sbq[$];
   int unsigned n_run  = 0;
   int unsigned n_fail = 0;
   int unsigned g_end  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   task automatic sb_push(input int unsigned at, input string tag, input logic [N-1:0] dom,
                          input logic [N-1:0] ack, input logic busy, input logic done);
      exp_t e;
      int   pos;
      e.at = at; e.tag = tag; e.dom = dom; e.ack = ack; e.busy = busy; e.done = done;
      pos = sbq.size();
      for (int i = 0; i < sbq.size(); i++) begin
         if (sbq[i].at > at) begin
            pos = i;
            break;
         end
      end
      sbq.insert(pos, e);
   endtask

   task automatic sb_flush(input int unsigned from);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
         if (sbq[i].at >= from) sbq.delete(i);
      end
   endtask

   function automatic int unsigned eff(input int unsigned d);
      return (d == 0) ? 1 : d;
   endfunction

   // Domain k (k >= first) is expected high from edge base + (k-first+1)*e on.
   task automatic exp_release(input int unsigned base, input int unsigned first,
                              input int unsigned e, input string tag);
      int unsigned total;
      logic [N-1:0] d;
      total = (N - first) * e;
      for (int unsigned t = 1; t <= total; t++) begin
         d = '0;
         for (int unsigned k = 0; k < N; k++) begin
            if (k < first) d[k] = 1'b1;
            else if (t >= (k - first + 1) * e) d[k] = 1'b1;
         end
         sb_push(base + t, tag, d, '0, (t < total), (t == total));
      end
      g_end = base + total;
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) @(negedge mclk);
   endtask

   // kind 0 = reset, 1 = full_rst_req; held for h edges, then released.
   task automatic hold_seq(input int kind, input int unsigned dly, input int unsigned h,
                           input string tag);
      int unsigned c;
      c = cyc;
      cfg_dly = DW'(dly);
      if (kind == 0) reset = 1'b1;
      else           full_rst_req = 1'b1;
      sb_flush(c + 1);
      for (int unsigned k = 1; k <= h; k++) sb_push(c + k, {tag, ".hold"}, '0, '0, 1'b1, 1'b0);
      exp_release(c + h, 0, eff(dly), tag);
      repeat (h) @(negedge mclk);
      reset        = 1'b0;
      full_rst_req = 1'b0;
   endtask

   task automatic soft_accept(input int unsigned at, input int unsigned i,
                              input int unsigned dly, input string tag);
      logic [N-1:0] d;
      logic [N-1:0] a;
      d = '0;
      a = '0;
      for (int unsigned k = 0; k < N; k++) if (k < i) d[k] = 1'b1;
      a[i] = 1'b1;
      sb_push(at, {tag, ".acc"}, d, a, 1'b1, 1'b0);
      exp_release(at, i, eff(dly), tag);
   endtask

   task automatic idle(input int unsigned n, input string tag);
      int unsigned s;
      s = g_end;
      for (int unsigned k = 1; k <= n; k++) sb_push(s + k, {tag, ".idle"}, '1, '0, 1'b0, 1'b1);
      wait_cyc(s + n);
      g_end = s + n;
   endtask

   // Scoreboard monitor, sampling away from the active edge
   always @(negedge mclk) begin
      while (sbq.size() > 0 && sbq[0].at <= cyc) begin
         exp_t e;
         e = sbq.pop_front();
         if (e.at < cyc) begin
            n_fail++;
            $display("FAIL %s: expectation for edge %0d missed (now %0d)", e.tag, e.at, cyc);
         end else begin
            chk({e.tag, ".dom"},  32'(dom_rst_n),  32'(e.dom));
            chk({e.tag, ".ack"},  32'(sw_rst_ack), 32'(e.ack));
            chk({e.tag, ".busy"}, 32'(seq_busy),   32'(e.busy));
            chk({e.tag, ".done"}, 32'(seq_done),   32'(e.done));
         end
      end
   end

   initial begin
      int unsigned a;
      reset        = 1'b1;
      full_rst_req = 1'b0;
      sw_rst_req   = '0;
      cfg_dly      = DW'(3);
      repeat (3) @(negedge mclk);

      // Power-on sequence, delay 3: 0001@3 0011@6 0111@9 1111@12
      hold_seq(0, 3, 1, "rst3");
      idle(3, "rst3");

      // Delay 0 behaves as 1
      hold_seq(0, 0, 1, "dly0");
      idle(2, "dly0");

      // Maximum delay
      hold_seq(0, 255, 1, "dly255");
      idle(2, "dly255");

      // Soft reset of domain 2 with delay 2
      cfg_dly    = DW'(2);
      sw_rst_req = 4'b0100;
      soft_accept(cyc + 1, 2, 2, "sw2");
      a = cyc + 1;
      wait_cyc(a);
      sw_rst_req = '0;
      idle(2, "sw2");

      // Two simultaneous requests: lowest first, the other after re-release
      cfg_dly    = DW'(2);
      sw_rst_req = 4'b1010;
      soft_accept(cyc + 1, 1, 2, "sw1010a");
      a = cyc + 1;
      wait_cyc(a);
      sw_rst_req[1] = 1'b0;
      a = g_end + 1;
      soft_accept(a, 3, 2, "sw1010b");
      wait_cyc(a);
      sw_rst_req[3] = 1'b0;
      idle(2, "sw1010b");

      // full_rst_req pulse mid-sequence restarts from scratch
      hold_seq(0, 3, 1, "base_f");
      wait_cyc(g_end - 6);
      hold_seq(1, 3, 1, "full_mid");
      idle(2, "full_mid");

      // reset pulse mid-sequence gives the same result
      hold_seq(0, 3, 1, "base_r");
      wait_cyc(g_end - 6);
      hold_seq(0, 3, 1, "rst_mid");
      idle(2, "rst_mid");

      // full_rst_req held several cycles, capturing a new delay
      hold_seq(1, 5, 4, "full_hold");
      idle(2, "full_hold");

      // Request during HOLD is deferred; cfg_dly change mid-sequence is ignored
      hold_seq(0, 3, 1, "hreq");
      sw_rst_req = 4'b0001;
      repeat (2) @(negedge mclk);
      cfg_dly = DW'(7);
      a = g_end + 1;
      soft_accept(a, 0, 7, "hacc");
      wait_cyc(a);
      sw_rst_req = '0;
      idle(2, "hacc");

      // Request arriving with full_rst_req is never acked that cycle
      sw_rst_req = 4'b0100;
      hold_seq(1, 2, 1, "full_sw");
      a = g_end + 1;
      soft_accept(a, 2, 2, "full_sw2");
      wait_cyc(a);
      sw_rst_req = '0;
      idle(3, "full_sw2");

      repeat (3) @(negedge mclk);
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL leftover: %0d expectations never reached, required 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, %0d expectations pending", sbq.size());
      $fatal(1, "timeout");
   end

endmodule
